// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for the multicycle CPU.
// Sequences each instruction through IF/ID/EXE/MEM/WB and drives the
// datapath write enables and selects.
//
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   opcode[5:0]         IR[31:26], meaningful from ID onward
//   zero                ALU zero flag, consumed in EXE_B
//   PCWre, IRWre, InsMemRW, mRD, mWR, RegWre   write/read enables
//   ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, RegDst[1:0],
//   PCSrc[1:0], ALUOp[2:0]                     datapath selects
//   state[3:0]          current state (debug)
//
// Configuration macro: JAL_JR_EN -- when defined, jal/jr execute; when
// undefined they decode as illegal opcodes (ID->IF, PC+4, no reg write).
module multicycle_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EXE_A = 4'd2, S_EXE_B = 4'd3, S_EXE_LS = 4'd4,
    S_MEM_R = 4'd5, S_MEM_W = 4'd6, S_WB_A = 4'd7, S_WB_L = 4'd8, S_HALT = 4'd9
  } state_e;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010,
                         OP_OR  = 6'b010000, OP_AND = 6'b010001, OP_ORI  = 6'b010010,
                         OP_SLT = 6'b100110, OP_SW  = 6'b110000, OP_LW   = 6'b110001,
                         OP_BEQ = 6'b110100, OP_J   = 6'b111000, OP_JR   = 6'b111001,
                         OP_JAL = 6'b111010, OP_HALT = 6'b111111;

  state_e state_q, state_d;

  // Opcode class decode
  logic is_rtype, is_imm, is_arith, is_jal, is_jr;
  always_comb begin
    is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
               (opcode == OP_AND) || (opcode == OP_SLT);
    is_imm   = (opcode == OP_ADDI) || (opcode == OP_ORI);
    is_arith = is_rtype || is_imm;
`ifdef JAL_JR_EN
    is_jal   = (opcode == OP_JAL);
    is_jr    = (opcode == OP_JR);
`else
    is_jal   = 1'b0;
    is_jr    = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID: begin
        if (is_arith)                               state_d = S_EXE_A;
        else if (opcode == OP_BEQ)                  state_d = S_EXE_B;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = S_EXE_LS;
        else if (opcode == OP_HALT)                 state_d = S_HALT;
        else                                        state_d = S_IF; // j/jal/jr/illegal
      end
      S_EXE_A:  state_d = S_WB_A;
      S_EXE_B:  state_d = S_IF;
      S_EXE_LS: state_d = (opcode == OP_LW) ? S_MEM_R : S_MEM_W;
      S_MEM_R:  state_d = S_WB_L;
      S_MEM_W:  state_d = S_IF;
      S_WB_A:   state_d = S_IF;
      S_WB_L:   state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  assign state = state_q;

  // Outputs are decoded combinationally from the current state: the IR only
  // becomes valid at the end of IF and zero is produced within EXE_B, so a
  // registered decode would see stale inputs. RST gates everything to 0 so
  // no write can slip out while reset is held.
  always_comb begin
    PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; mRD = 1'b0; mWR = 1'b0;
    RegWre = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ExtSel = 1'b0;
    DBDataSrc = 1'b0; WrRegDSrc = 1'b0; RegDst = 2'b00; PCSrc = 2'b00;
    ALUOp = 3'b000;
    if (!RST) begin
      case (state_q)
        S_IF: begin
          IRWre = 1'b1; InsMemRW = 1'b1;
        end
        S_ID: begin
          if (opcode == OP_J || is_jal) begin
            PCWre = 1'b1; PCSrc = 2'b11;
            RegWre = is_jal;          // jal links to $31 (RegDst 00) with PC+4
          end else if (is_jr) begin
            PCWre = 1'b1; PCSrc = 2'b10;
          end else if (!is_arith && opcode != OP_BEQ && opcode != OP_LW &&
                       opcode != OP_SW && opcode != OP_HALT) begin
            PCWre = 1'b1;             // illegal: skip to PC+4
          end
        end
        S_EXE_A: begin
          ALUSrcB = is_imm;
          ExtSel  = (opcode != OP_ORI);
          case (opcode)
            OP_SUB:         ALUOp = 3'b001;
            OP_OR, OP_ORI:  ALUOp = 3'b011;
            OP_AND:         ALUOp = 3'b100;
            OP_SLT:         ALUOp = 3'b110;
            default:        ALUOp = 3'b000;
          endcase
        end
        S_EXE_B: begin
          ALUOp = 3'b001; PCWre = 1'b1; ExtSel = 1'b1;
          PCSrc = zero ? 2'b01 : 2'b00;
        end
        S_EXE_LS: begin
          ALUSrcB = 1'b1; ExtSel = 1'b1;
        end
        S_MEM_R: mRD = 1'b1;
        S_MEM_W: begin
          mWR = 1'b1; PCWre = 1'b1;
        end
        S_WB_A: begin
          RegWre = 1'b1; WrRegDSrc = 1'b1; PCWre = 1'b1;
          RegDst = is_rtype ? 2'b10 : 2'b01;
        end
        S_WB_L: begin
          RegWre = 1'b1; RegDst = 2'b01; WrRegDSrc = 1'b1; DBDataSrc = 1'b1;
          PCWre = 1'b1;
        end
        default: ; // HALT: everything idle
      endcase
    end
  end

endmodule
